// File: rtl/token_fork_eager.sv
// token_fork_eager
//   Eager fork stage for handshake token nets. One token enters on a single
//   valid/ready port. It is copied to every output branch that its mask
//   selects. Each branch accepts its copy on its own. The input token retires
//   only after every selected branch has taken its copy.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   i_valid    upstream token present
//   o_ready    stage can accept a token this cycle. This output depends
//              combinationally on i_ready.
//   i_mask     branches that should receive the token; sampled on accept
//   o_valid    per-branch token present, decoded from registers only
//   i_ready    per-branch downstream accept
//   o_busy     a token is held and distribution is in progress
//   o_tok_cnt  count of fully distributed tokens; wraps to zero
//   o_err      one-cycle pulse after a token is accepted with an empty mask
module token_fork_eager #(
  parameter int N_OUT = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [N_OUT-1:0] i_mask,
  output logic [N_OUT-1:0] o_valid,
  input  logic [N_OUT-1:0] i_ready,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_tok_cnt,
  output logic             o_err
);

  typedef enum logic {IDLE = 1'b0, DIST = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [N_OUT-1:0]   mask_q, mask_d;
  logic [N_OUT-1:0]   done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [N_OUT-1:0]   xfer;
  logic               all_done_next;
  logic               accept;

  // Outputs come only from registers. In IDLE, mask_q may still hold the
  // last token's mask, so the outputs are gated by the state.
  assign o_valid = (state_q == DIST) ? (mask_q & ~done_q) : '0;
  assign xfer    = o_valid & i_ready;

  // A branch counts as finished when it is already done or transfers this
  // cycle.
  assign all_done_next = (((done_q | xfer) & mask_q) == mask_q);

  // The stage reports ready on the completion cycle, so a new token can
  // load at the same edge and back-to-back tokens have no bubble.
  assign o_ready   = (state_q == IDLE) || all_done_next;
  assign accept    = i_valid && o_ready;
  assign o_busy    = (state_q == DIST);
  assign o_tok_cnt = cnt_q;
  assign o_err     = err_q;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    if (state_q == DIST) begin
      done_d = done_q | xfer;
      if (all_done_next) begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = IDLE;
      end
    end

    // A new token overrides the completion bookkeeping for mask and done.
    if (accept) begin
      mask_d  = i_mask;
      done_d  = '0;
      state_d = (|i_mask) ? DIST : IDLE;
      err_d   = ~(|i_mask);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_token_fork_eager.sv
// Directed bench for token_fork_eager (N_OUT=3, CNT_W=8). Inputs change 1
// time unit after a rising edge. Outputs are checked mid-cycle.
module tb_token_fork_eager;

  logic       clk;
  logic       rst;
  logic       i_valid;
  logic       o_ready;
  logic [2:0] i_mask;
  logic [2:0] o_valid;
  logic [2:0] i_ready;
  logic       o_busy;
  logic [7:0] o_tok_cnt;
  logic       o_err;

  int checks;
  int failures;
  int exp_cnt;

  token_fork_eager #(.N_OUT(3), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_mask    (i_mask),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_busy    (o_busy),
    .o_tok_cnt (o_tok_cnt),
    .o_err     (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 0;
    rst      = 1'b0;
    i_valid  = 1'b0;
    i_mask   = 3'b000;
    i_ready  = 3'b000;

    // Reset state
    #3;
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_ready", 32'(o_ready), 32'h1);
    chk("rst_busy",  32'(o_busy),  32'h0);
    chk("rst_cnt",   32'(o_tok_cnt), 32'h0);
    chk("rst_err",   32'(o_err),   32'h0);
    #9 rst = 1'b1;                       // t=12, away from any edge

    // Full-mask streaming: every branch always ready
    i_valid = 1'b1; i_mask = 3'b111; i_ready = 3'b111;
    #1;
    chk("str_pre_valid", 32'(o_valid), 32'h0);
    step();                              // first accept
    for (int i = 0; i < 4; i++) begin
      chk("str_valid", 32'(o_valid), 32'h7);
      chk("str_ready", 32'(o_ready), 32'h1);
      chk("str_cnt",   32'(o_tok_cnt), 32'(exp_cnt));
      step();
      exp_cnt++;
    end
    i_valid = 1'b0;
    chk("str_last_cnt", 32'(o_tok_cnt), 32'(exp_cnt));
    step();
    exp_cnt++;
    chk("str_drain_cnt",  32'(o_tok_cnt), 32'(exp_cnt));
    chk("str_drain_busy", 32'(o_busy), 32'h0);
    chk("str_drain_valid", 32'(o_valid), 32'h0);

    // Partial mask 101 with staggered branch acceptance
    i_valid = 1'b1; i_mask = 3'b101; i_ready = 3'b000;
    step();
    i_valid = 1'b0; i_mask = 3'b010; i_ready = 3'b001;
    #1;
    chk("pm_valid0", 32'(o_valid), 32'h5);
    chk("pm_ready0", 32'(o_ready), 32'h0);
    step();
    chk("pm_valid1", 32'(o_valid), 32'h4);
    chk("pm_ready1", 32'(o_ready), 32'h0);
    step();
    chk("pm_valid2", 32'(o_valid), 32'h4);
    chk("pm_ready2", 32'(o_ready), 32'h0);
    i_ready = 3'b100;
    #1;
    chk("pm_ready3", 32'(o_ready), 32'h1);
    chk("pm_cnt3",   32'(o_tok_cnt), 32'(exp_cnt));
    step();
    exp_cnt++;
    chk("pm_cnt_done", 32'(o_tok_cnt), 32'(exp_cnt));
    chk("pm_idle_valid", 32'(o_valid), 32'h0);

    // Zero mask: error pulse, no count, next token accepted immediately
    i_valid = 1'b1; i_mask = 3'b000; i_ready = 3'b000;
    #1;
    chk("zm_ready", 32'(o_ready), 32'h1);
    step();
    i_mask = 3'b011;
    #1;
    chk("zm_err",   32'(o_err),  32'h1);
    chk("zm_busy",  32'(o_busy), 32'h0);
    chk("zm_cnt",   32'(o_tok_cnt), 32'(exp_cnt));
    chk("zm_ready2", 32'(o_ready), 32'h1);
    step();
    i_valid = 1'b0;
    #1;
    chk("zm_err_gone", 32'(o_err),  32'h0);
    chk("zm_next_busy", 32'(o_busy), 32'h1);
    chk("zm_next_valid", 32'(o_valid), 32'h3);

    // Stall for 10 cycles with i_mask churning underneath
    i_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      i_mask = 3'(i + 4);
      #1;
      chk("stall_valid", 32'(o_valid), 32'h3);
      chk("stall_ready", 32'(o_ready), 32'h0);
      chk("stall_busy",  32'(o_busy),  32'h1);
      step();
    end

    // One branch finishes, then reset is pulled mid-distribution
    i_valid = 1'b0; i_ready = 3'b001;
    step();
    i_ready = 3'b000;
    #1;
    chk("mr_valid_pre", 32'(o_valid), 32'h2);
    rst = 1'b0;
    #1;
    chk("mr_valid", 32'(o_valid), 32'h0);
    chk("mr_busy",  32'(o_busy),  32'h0);
    chk("mr_cnt",   32'(o_tok_cnt), 32'h0);
    #1 rst = 1'b1;
    exp_cnt = 0;
    i_valid = 1'b1; i_mask = 3'b110; i_ready = 3'b110;
    step();
    i_valid = 1'b0;
    #1;
    chk("post_valid", 32'(o_valid), 32'h6);
    chk("post_ready", 32'(o_ready), 32'h1);
    step();
    exp_cnt++;
    chk("post_cnt",  32'(o_tok_cnt), 32'(exp_cnt));
    chk("post_busy", 32'(o_busy), 32'h0);

    // Counter wrap: stream single-branch tokens until 255 rolls over to 0
    i_valid = 1'b1; i_mask = 3'b001; i_ready = 3'b001;
    step();                              // accept, no completion yet
    while (exp_cnt < 255) begin
      step();
      exp_cnt++;
    end
    chk("wrap_255", 32'(o_tok_cnt), 32'd255);
    chk("wrap_ready", 32'(o_ready), 32'h1);
    step();
    exp_cnt = (exp_cnt + 1) % 256;
    chk("wrap_0", 32'(o_tok_cnt), 32'(exp_cnt));
    i_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/token_fork_eager.md
Name: token_fork_eager

Overview:
- Eager fork stage for handshake token nets. The complementary direction to the registered join/merge stages.
- Accepts one token on a single valid/ready input and replicates it to up to N_OUT output branches selected by a per-token mask.
- Each branch accepts independently. The input token retires only when every selected branch has taken its copy.
- Sits upstream of join stages, distributing a transition's firing to its successor places.

Parameters:
N_OUT, 3, number of output branches (2..8)
CNT_W, 8, width of completed-token counter

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted at 0)
i_valid  input  1  upstream token present
o_ready  output  1  stage can accept a token this cycle
i_mask  input  N_OUT  branches to receive the token; sampled with token
o_valid  output  N_OUT  per-branch token present
i_ready  input  N_OUT  per-branch downstream accept
o_busy  output  1  token held, distribution in progress
o_tok_cnt  output  CNT_W  count of fully distributed tokens
o_err  output  1  one-cycle pulse: token accepted with zero mask

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; mask_q=0; done=0; o_valid=0; o_busy=0; o_tok_cnt=0; o_err=0.
  - o_ready=1 once state is IDLE.
- States:
  - IDLE: no token held.
  - DIST: token held, branches pending.
- Accept: occurs when i_valid & o_ready at a rising edge. mask_q<=i_mask; done<=0.
  - Nonzero mask -> DIST.
  - Zero mask -> stay IDLE, o_err=1 next cycle only, counter unchanged.
- Latency: token accepted at edge t; o_valid visible in cycle after t (1-cycle registered).
- In DIST:
  - o_valid[k] = mask_q[k] & ~done[k] (decoded from registers, no combinational path from i_ready).
  - Branch k transfers when o_valid[k] & i_ready[k]; done[k] set at that edge.
  - Once set, done[k] holds; o_valid[k] drops and stays low for this token regardless of i_ready.
- all_done_next = every k with mask_q[k] has done[k] or transfers this cycle.
- o_ready = (state==IDLE) | (state==DIST & all_done_next).
  - Back-to-back tokens are supported with no bubble.
  - o_ready depends combinationally on i_ready (documented path).
- Completion edge (DIST & all_done_next):
  - o_tok_cnt increments by 1, wraps modulo 2^CNT_W.
  - If a new token is accepted at the same edge, reload mask_q/done for it and remain/enter DIST per its mask.
  - Otherwise -> IDLE.
- Simultaneous transfers on multiple branches in one cycle are all honoured.
- o_busy = (state==DIST).
- i_mask is ignored when no accept occurs; changes to i_mask mid-distribution have no effect.
- i_valid may deassert without acceptance (no upstream stickiness required).
- Reset mid-DIST: held token is discarded, counter cleared, all o_valid low immediately (async).
- Mask bits beyond used branches: not applicable; all N_OUT bits are significant.

Test Plan:
- Reset release, N_OUT=3, i_valid=1, i_mask=3'b111, i_ready=3'b111 every cycle -> o_valid=3'b111 one cycle after each accept; o_ready stays 1; o_tok_cnt increments every cycle (1,2,3...).
- i_mask=3'b101, i_ready=3'b001 for 2 cycles, then 3'b100 -> o_valid 3'b101, then 3'b100, then branch 2 transfers; o_ready=1 only in that final cycle; o_tok_cnt=1; o_valid[1] never asserted.
- Accept with i_mask=0 -> o_err=1 for exactly one cycle; o_busy stays 0; o_tok_cnt unchanged; next token accepted immediately.
- Hold i_ready=0 with token in DIST for 10 cycles while toggling i_mask -> o_valid constant at original mask; o_ready=0; o_busy=1.
- Pull rst low mid-DIST (one branch done) -> o_valid=0, o_busy=0, o_tok_cnt=0 asynchronously; after release the next token distributes normally.
- CNT_W=8: complete 256 tokens -> o_tok_cnt wraps 255 -> 0.
